// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_pkg
//  Brief    : Shared widths, FSM state encoding and the load-use hazard
//             helper for the pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Register-file index width.
    localparam int c_REG_IDX_W = 5;

    // Bubble counter width; covers LU_BUBBLES up to 7.
    localparam int c_LU_CNT_W  = 3;

    // Controller states.
    typedef enum logic [1:0] {
        HZ_RUN = 2'd0,
        HZ_LU  = 2'd1,
        HZ_MEM = 2'd2
    } hz_state_t;

    // Per-cycle stage control bundle.
    typedef struct packed {
        logic if_hold;
        logic id_hold;
        logic ex_hold;
        logic mem_hold;
        logic if_id_flush;
        logic id_ex_flush;
    } hz_ctrl_t;

    // A load in EX whose destination is read by the instruction in ID.
    // x0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic f_lu_hit(
        input logic                   visit,
        input logic                   wb,
        input logic [c_REG_IDX_W-1:0] rd,
        input logic [c_REG_IDX_W-1:0] rs1,
        input logic                   rs1_used,
        input logic [c_REG_IDX_W-1:0] rs2,
        input logic                   rs2_used
    );
        return visit & wb & (rd != '0) &
               ((rs1_used & (rs1 == rd)) | (rs2_used & (rs2 == rd)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Brief    : Pipeline-to-hazard-controller signal bundle. The pipeline side
//             (master) presents decode/EX/MEM status; the controller side
//             (slave) returns stage holds, flushes and the timeout flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;

    logic [hazard_ctrl_pkg::c_REG_IDX_W-1:0] id_rs1_idx_i;
    logic [hazard_ctrl_pkg::c_REG_IDX_W-1:0] id_rs2_idx_i;
    logic                                    id_rs1_used_i;
    logic                                    id_rs2_used_i;
    logic [hazard_ctrl_pkg::c_REG_IDX_W-1:0] ex_rd_idx_i;
    logic                                    ex_wb_sig_i;
    logic                                    ex_visit_sig_i;
    logic                                    ex_redirect_i;
    logic                                    mem_req_i;
    logic                                    mem_ack_i;

    logic                                    if_hold_o;
    logic                                    id_hold_o;
    logic                                    ex_hold_o;
    logic                                    mem_hold_o;
    logic                                    if_id_flush_o;
    logic                                    id_ex_flush_o;
    logic                                    mem_timeout_o;

    modport master (
        output id_rs1_idx_i, id_rs2_idx_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_idx_i, ex_wb_sig_i, ex_visit_sig_i, ex_redirect_i,
               mem_req_i, mem_ack_i,
        input  if_hold_o, id_hold_o, ex_hold_o, mem_hold_o,
               if_id_flush_o, id_ex_flush_o, mem_timeout_o
    );

    modport slave (
        input  id_rs1_idx_i, id_rs2_idx_i, id_rs1_used_i, id_rs2_used_i,
               ex_rd_idx_i, ex_wb_sig_i, ex_visit_sig_i, ex_redirect_i,
               mem_req_i, mem_ack_i,
        output if_hold_o, id_hold_o, ex_hold_o, mem_hold_o,
               if_id_flush_o, id_ex_flush_o, mem_timeout_o
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_perf_cnt
//  Brief    : Free-running 32-bit stall and flush cycle counters. Present
//             only when HAZARD_PERF_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt (
    input  wire logic        clk,
    input  wire logic        rst,          // synchronous, active-low
    input  wire logic        i_stall,
    input  wire logic        i_flush,
    output logic      [31:0] o_stall_cnt,
    output logic      [31:0] o_flush_cnt
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Count stalled and flushed cycles; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (i_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule
`endif
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline hazard controller. Detects load-use hazards, EX-stage
//             redirects and multi-cycle data-memory waits, and drives the
//             stage holds / flushes through a three-state FSM with a bubble
//             counter and a saturating memory-wait timeout counter.
//             Optional macro HAZARD_PERF_CNT_EN adds stall/flush counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,   // bubbles per load-use hazard, 1..7
    parameter int MEM_TO_W   = 8    // memory-wait timeout counter width
) (
    input  wire logic        clk,
    input  wire logic        rst,   // synchronous, active-low
    hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic      [31:0] stall_cnt_o,
    output logic      [31:0] flush_cnt_o
`endif
);

    localparam logic [c_LU_CNT_W-1:0] c_LU_INIT = c_LU_CNT_W'(LU_BUBBLES - 1);
    localparam logic [c_LU_CNT_W-1:0] c_LU_ONE  = c_LU_CNT_W'(1);
    localparam logic [MEM_TO_W-1:0]   c_TO_MAX  = '1;
    localparam logic [MEM_TO_W-1:0]   c_TO_ONE  = MEM_TO_W'(1);

    hz_state_t              r_state;
    hz_state_t              w_state_nxt;
    logic [c_LU_CNT_W-1:0]  r_lu_cnt;
    logic [c_LU_CNT_W-1:0]  w_lu_cnt_nxt;
    logic [MEM_TO_W-1:0]    r_to_cnt;
    logic [MEM_TO_W-1:0]    w_to_cnt_nxt;
    logic [MEM_TO_W-1:0]    w_to_inc;
    logic                   r_timeout;
    logic                   w_timeout_nxt;
    logic                   w_mem_wait;
    logic                   w_lu_hit;
    hz_ctrl_t               w_ctrl;

    // A memory access that does not complete this cycle; a same-cycle ack
    // is a zero-wait access and never stalls.
    assign w_mem_wait = hz.mem_req_i & ~hz.mem_ack_i;

    assign w_lu_hit = f_lu_hit(hz.ex_visit_sig_i, hz.ex_wb_sig_i, hz.ex_rd_idx_i,
                               hz.id_rs1_idx_i, hz.id_rs1_used_i,
                               hz.id_rs2_idx_i, hz.id_rs2_used_i);

    // Saturating increment of the wait counter.
    assign w_to_inc = (r_to_cnt == c_TO_MAX) ? r_to_cnt : (r_to_cnt + c_TO_ONE);

    // Next-state, counter updates and stage controls.
    always_comb begin
        w_state_nxt   = r_state;
        w_lu_cnt_nxt  = r_lu_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_timeout_nxt = r_timeout;
        w_ctrl        = '0;

        case (r_state)
            HZ_RUN: begin
                if (w_mem_wait) begin
                    w_ctrl.if_hold  = 1'b1;
                    w_ctrl.id_hold  = 1'b1;
                    w_ctrl.ex_hold  = 1'b1;
                    w_ctrl.mem_hold = 1'b1;
                    w_to_cnt_nxt    = w_to_inc;
                    w_state_nxt     = HZ_MEM;
                end else if (hz.ex_redirect_i) begin
                    // The ID instruction is squashed, so its load-use
                    // dependency no longer matters.
                    w_ctrl.if_id_flush = 1'b1;
                    w_ctrl.id_ex_flush = 1'b1;
                end else if (w_lu_hit) begin
                    w_ctrl.if_hold     = 1'b1;
                    w_ctrl.id_hold     = 1'b1;
                    w_ctrl.id_ex_flush = 1'b1;
                    w_lu_cnt_nxt       = c_LU_INIT;
                    w_state_nxt        = (LU_BUBBLES > 1) ? HZ_LU : HZ_RUN;
                end
            end

            HZ_LU: begin
                if (w_mem_wait) begin
                    // Memory wait pre-empts; remaining bubbles are kept and
                    // resumed once the access completes.
                    w_ctrl.if_hold  = 1'b1;
                    w_ctrl.id_hold  = 1'b1;
                    w_ctrl.ex_hold  = 1'b1;
                    w_ctrl.mem_hold = 1'b1;
                    w_to_cnt_nxt    = w_to_inc;
                    w_state_nxt     = HZ_MEM;
                end else begin
                    // EX only holds inserted bubbles here, so redirects and
                    // new load-use hits cannot originate from it.
                    w_ctrl.if_hold     = 1'b1;
                    w_ctrl.id_hold     = 1'b1;
                    w_ctrl.id_ex_flush = 1'b1;
                    if (r_lu_cnt <= c_LU_ONE) begin
                        w_lu_cnt_nxt = '0;
                        w_state_nxt  = HZ_RUN;
                    end else begin
                        w_lu_cnt_nxt = r_lu_cnt - c_LU_ONE;
                    end
                end
            end

            HZ_MEM: begin
                if (hz.mem_ack_i) begin
                    // Holds release in the ack cycle. A redirect seen while
                    // frozen is re-presented by EX in the following cycle.
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = (r_lu_cnt != '0) ? HZ_LU : HZ_RUN;
                end else begin
                    w_ctrl.if_hold  = 1'b1;
                    w_ctrl.id_hold  = 1'b1;
                    w_ctrl.ex_hold  = 1'b1;
                    w_ctrl.mem_hold = 1'b1;
                    w_to_cnt_nxt    = w_to_inc;
                end
            end

            default: begin
                w_state_nxt = HZ_RUN;
            end
        endcase

        if (w_to_cnt_nxt == c_TO_MAX) begin
            w_timeout_nxt = 1'b1;
        end
    end

    // State, bubble counter, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= HZ_RUN;
            r_lu_cnt  <= '0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lu_cnt  <= w_lu_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Every output is forced low while reset is asserted.
    assign hz.if_hold_o     = rst & w_ctrl.if_hold;
    assign hz.id_hold_o     = rst & w_ctrl.id_hold;
    assign hz.ex_hold_o     = rst & w_ctrl.ex_hold;
    assign hz.mem_hold_o    = rst & w_ctrl.mem_hold;
    assign hz.if_id_flush_o = rst & w_ctrl.if_id_flush;
    assign hz.id_ex_flush_o = rst & w_ctrl.id_ex_flush;
    assign hz.mem_timeout_o = rst & r_timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic w_any_hold;

    assign w_any_hold = hz.if_hold_o | hz.id_hold_o | hz.ex_hold_o | hz.mem_hold_o;

    hazard_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_stall     (w_any_hold),
        .i_flush     (hz.id_ex_flush_o),
        .o_stall_cnt (stall_cnt_o),
        .o_flush_cnt (flush_cnt_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Two controller instances (1 bubble / 8-bit timeout and
//             3 bubbles / 4-bit timeout) driven with identical directed and
//             random stimulus, checked against a cycle-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] s_rs1, s_rs2, s_rd;
    logic       s_u1, s_u2, s_wb, s_vis, s_redir, s_req, s_ack;

    always #5 clk = ~clk;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();

    assign if_a.id_rs1_idx_i = s_rs1;   assign if_b.id_rs1_idx_i = s_rs1;
    assign if_a.id_rs2_idx_i = s_rs2;   assign if_b.id_rs2_idx_i = s_rs2;
    assign if_a.id_rs1_used_i = s_u1;   assign if_b.id_rs1_used_i = s_u1;
    assign if_a.id_rs2_used_i = s_u2;   assign if_b.id_rs2_used_i = s_u2;
    assign if_a.ex_rd_idx_i = s_rd;     assign if_b.ex_rd_idx_i = s_rd;
    assign if_a.ex_wb_sig_i = s_wb;     assign if_b.ex_wb_sig_i = s_wb;
    assign if_a.ex_visit_sig_i = s_vis; assign if_b.ex_visit_sig_i = s_vis;
    assign if_a.ex_redirect_i = s_redir; assign if_b.ex_redirect_i = s_redir;
    assign if_a.mem_req_i = s_req;      assign if_b.mem_req_i = s_req;
    assign if_a.mem_ack_i = s_ack;      assign if_b.mem_ack_i = s_ack;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] w_sc_a, w_fc_a, w_sc_b, w_fc_b;
`endif

    hazard_ctrl #(.LU_BUBBLES(1), .MEM_TO_W(8)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .hz  (if_a.slave)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o (w_sc_a), .flush_cnt_o (w_fc_a)
`endif
    );

    hazard_ctrl #(.LU_BUBBLES(3), .MEM_TO_W(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .hz  (if_b.slave)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt_o (w_sc_b), .flush_cnt_o (w_fc_b)
`endif
    );

    // Observed vector: {if_hold, id_hold, ex_hold, mem_hold, if_id_flush, id_ex_flush, timeout}
    wire logic [6:0] w_got_a = {if_a.if_hold_o, if_a.id_hold_o, if_a.ex_hold_o, if_a.mem_hold_o,
                                if_a.if_id_flush_o, if_a.id_ex_flush_o, if_a.mem_timeout_o};
    wire logic [6:0] w_got_b = {if_b.if_hold_o, if_b.id_hold_o, if_b.ex_hold_o, if_b.mem_hold_o,
                                if_b.if_id_flush_o, if_b.id_ex_flush_o, if_b.mem_timeout_o};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bubbles still owed, memory outstanding, consecutive
    // wait cycles and the sticky flag, per instance.
    int lu_n   [2] = '{1, 3};
    int to_max [2] = '{255, 15};
    int owed   [2];
    bit busy   [2];
    int waitc  [2];
    bit tflag  [2];

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs for the current inputs, then advance to the next cycle.
    task automatic mdl_step(input int k, output logic [6:0] e);
        bit hit, stall_mem;
        e = '0;
        if (!rst) begin
            owed[k] = 0; busy[k] = 0; waitc[k] = 0; tflag[k] = 0;
            return;
        end
        hit = s_vis && s_wb && (s_rd != 0) &&
              ((s_u1 && s_rs1 == s_rd) || (s_u2 && s_rs2 == s_rd));
        stall_mem = busy[k] ? !s_ack : (s_req && !s_ack);
        e[0] = tflag[k];
        if (stall_mem) begin
            e[6:3] = 4'b1111;
            busy[k] = 1;
            if (waitc[k] < to_max[k]) waitc[k]++;
            if (waitc[k] == to_max[k]) tflag[k] = 1;
        end else if (busy[k]) begin
            busy[k] = 0;
            waitc[k] = 0;
        end else if (owed[k] > 0) begin
            e[6] = 1; e[5] = 1; e[1] = 1;
            owed[k]--;
        end else if (s_redir) begin
            e[2] = 1; e[1] = 1;
        end else if (hit) begin
            e[6] = 1; e[5] = 1; e[1] = 1;
            owed[k] = lu_n[k] - 1;
        end
    endtask

    task automatic cycle(input string tag);
        logic [6:0] ea, eb;
        @(negedge clk);
        mdl_step(0, ea);
        mdl_step(1, eb);
        chk({tag, "/a"}, w_got_a, ea);
        chk({tag, "/b"}, w_got_b, eb);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1;
        s_rs1 = '0; s_rs2 = '0; s_rd = '0;
        s_u1 = 0; s_u2 = 0; s_wb = 0; s_vis = 0; s_redir = 0; s_req = 0; s_ack = 0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        s_vis = 1; s_wb = 1; s_rd = rd; s_rs1 = rs1; s_u1 = u1; s_rs2 = rs2; s_u2 = u2;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        cycle("reset0");
        cycle("reset1");
        idle();
        cycle("idle");

        // Load x5 followed by a reader of x5.
        load_use(5'd5, 5'd5, 1, 5'd0, 0);
        cycle("lu_hit");
        idle();
        repeat (4) cycle("lu_after");

        // x0 destination, and an unused rs2 match: no stall.
        load_use(5'd0, 5'd0, 1, 5'd0, 1);
        cycle("lu_x0");
        load_use(5'd5, 5'd1, 1, 5'd5, 0);
        cycle("lu_rs2_unused");
        load_use(5'd5, 5'd1, 1, 5'd5, 1);
        cycle("lu_rs2_used");
        idle();
        repeat (4) cycle("lu_rs2_after");

        // Three wait cycles then the ack.
        s_req = 1;
        repeat (3) cycle("mem_wait3");
        s_ack = 1;
        cycle("mem_ack3");
        idle();
        cycle("mem_after3");

        // Zero-wait access.
        s_req = 1; s_ack = 1;
        cycle("mem_zero_wait");
        idle();

        // Twenty unacknowledged cycles: the short-timeout instance trips.
        s_req = 1;
        repeat (20) cycle("mem_to");
        s_ack = 1;
        cycle("mem_to_ack");
        idle();
        repeat (3) cycle("mem_to_sticky");
        rst = 1'b0;
        cycle("mem_to_rst");
        idle();
        cycle("mem_to_clr");

        // Redirect coincident with a load-use hit.
        load_use(5'd7, 5'd7, 1, 5'd7, 1);
        s_redir = 1;
        cycle("redir_lu");
        idle();
        cycle("redir_after");

        // Reset on the second stall cycle of a multi-bubble stall.
        load_use(5'd9, 5'd9, 1, 5'd0, 0);
        cycle("lu_rst_1");
        idle();
        rst = 1'b0;
        cycle("lu_rst_2");
        idle();
        repeat (3) cycle("lu_rst_after");

        // Memory wait pre-empting a bubble sequence, then resuming it.
        load_use(5'd3, 5'd0, 0, 5'd3, 1);
        cycle("pre_lu");
        idle();
        s_req = 1;
        repeat (2) cycle("pre_wait");
        s_ack = 1;
        cycle("pre_ack");
        idle();
        repeat (4) cycle("pre_resume");

        // Random traffic with periodic long no-ack stretches.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 99) != 0);
            s_rd    = 5'($urandom_range(0, 3));
            s_rs1   = 5'($urandom_range(0, 3));
            s_rs2   = 5'($urandom_range(0, 3));
            s_u1    = 1'($urandom_range(0, 1));
            s_u2    = 1'($urandom_range(0, 1));
            s_wb    = ($urandom_range(0, 3) != 0);
            s_vis   = ($urandom_range(0, 3) != 0);
            s_redir = ($urandom_range(0, 7) == 0);
            s_req   = ($urandom_range(0, 3) == 0);
            s_ack   = ((i % 400) < 25) ? 1'b0 : ($urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that drives the `hold`/flush inputs of the IF/ID, ID/EX and EX/MEM stage registers.
- It consumes the decoded register indices and the `wb`/`visit` signals that leave ID and are presented at the ID/EX register outputs.
- It detects load-use hazards, EX-stage control redirects and multi-cycle data-memory waits.
- It sequences stall/bubble/flush cycles through a small FSM, with a bubble counter and a memory-wait timeout counter.

Parameters:
- LU_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7).
- MEM_TO_W, 8, width of the memory-wait timeout counter; timeout fires at 2^MEM_TO_W-1 wait cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- id_rs1_idx_i  in  5  rs1 index of instruction in ID.
- id_rs2_idx_i  in  5  rs2 index of instruction in ID.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_rd_idx_i  in  5  rd index at ID/EX output.
- ex_wb_sig_i  in  1  EX instruction writes back.
- ex_visit_sig_i  in  1  EX instruction accesses memory (load when wb=1).
- ex_redirect_i  in  1  EX resolved taken branch/jump.
- mem_req_i  in  1  MEM stage has an outstanding access.
- mem_ack_i  in  1  data memory completes the access this cycle.
- if_hold_o  out  1  freeze PC/IF.
- id_hold_o  out  1  IF/ID hold.
- ex_hold_o  out  1  ID/EX hold.
- mem_hold_o  out  1  EX/MEM hold.
- if_id_flush_o  out  1  load NOP into IF/ID.
- id_ex_flush_o  out  1  load bubble (reset value) into ID/EX.
- mem_timeout_o  out  1  sticky memory-wait timeout flag.

Behaviour:
- While rst=0 at a clock edge:
  - state<=RUN, bubble counter<=0, timeout counter<=0, mem_timeout_o<=0.
  - All outputs are 0 during that cycle.
  - Reset mid-stall or mid-wait abandons the operation immediately.
- FSM states:
  - RUN: normal flow.
  - LU_STALL: bubbles pending.
  - MEM_WAIT: memory outstanding.
- Hazard terms:
  - lu_hit = ex_visit_sig_i & ex_wb_sig_i & (ex_rd_idx_i!=0) & ((id_rs1_used_i & id_rs1_idx_i==ex_rd_idx_i) | (id_rs2_used_i & id_rs2_idx_i==ex_rd_idx_i)).
  - x0 never hazards.
- Priority within a cycle: mem wait > redirect > load-use.
- RUN:
  - If mem_req_i & !mem_ack_i: all four holds=1, no flush, next state MEM_WAIT.
  - Else if ex_redirect_i: if_id_flush_o=1 and id_ex_flush_o=1, holds=0, remain RUN. The load-use check is suppressed because the ID instruction is squashed.
  - Else if lu_hit: if_hold_o=id_hold_o=1, id_ex_flush_o=1, counter<=LU_BUBBLES-1. Next state is LU_STALL if LU_BUBBLES>1, else RUN.
  - Else all outputs 0.
- LU_STALL:
  - Outputs: if_hold_o=id_hold_o=1 and id_ex_flush_o=1 each cycle; counter decrements.
  - At 0, return to RUN.
  - mem_req_i & !mem_ack_i pre-empts: go to MEM_WAIT. Counter is retained, and on exit the FSM resumes LU_STALL if counter!=0.
- MEM_WAIT:
  - Outputs: all holds=1, flushes=0; timeout counter increments, saturating.
  - On reaching 2^MEM_TO_W-1, mem_timeout_o<=1 (sticky until reset); the FSM remains in MEM_WAIT.
  - On mem_ack_i: holds drop in the same cycle (combinational), timeout counter<=0, next state RUN (or LU_STALL per retained counter).
  - ex_redirect_i asserted during MEM_WAIT is ignored. EX is frozen, so the redirect is re-seen and acted on in the first RUN cycle.
- mem_req_i & mem_ack_i in the same cycle: zero-wait access, no stall.
- Outputs are combinational from state and inputs. State and counters are registered.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cnt_o[31:0] (cycles with any hold=1) and flush_cnt_o[31:0] (cycles with id_ex_flush_o=1).
  - Both counters wrap at 2^32 and reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header:
  - `REG_IDX` width.
  - FSM state encodings HZ_RUN=2'd0, HZ_LU=2'd1, HZ_MEM=2'd2.
- One sub-module, hazard_perf_cnt: the two 32-bit counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load x5 in EX (visit=1, wb=1, rd=5); ID add reads rs1=5 -> one cycle with if_hold_o=id_hold_o=id_ex_flush_o=1, then all 0.
- Same as above but rd=0, or ID has rs2=5 with id_rs2_used_i=0 -> no stall.
- mem_req_i=1, mem_ack_i low for 3 cycles -> 3 cycles all holds=1, then 0 on the ack cycle; mem_timeout_o stays 0.
- MEM_TO_W=4, no ack for 20 cycles -> mem_timeout_o=1 from cycle 15 onward and stays high after ack; cleared only by rst=0.
- ex_redirect_i=1 coincident with lu_hit -> if_id_flush_o=id_ex_flush_o=1, if_hold_o=0.
- LU_BUBBLES=3, lu_hit, rst=0 on the 2nd stall cycle -> all outputs 0 next cycle, state RUN.
